// File: rtl/instruction_queue.sv
// Decoupling FIFO between instruction fetch and the decoder: holds {pc, code, illegal}
// entries and presents the head with a valid/ready handshake; flush empties it in one cycle.
module instruction_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       flush_i,
    input  logic [XLEN-1:0]            fetch_pc_i,
    input  logic [31:0]                fetch_code_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    output logic [XLEN-1:0]            dec_pc_o,
    output logic [31:0]                dec_code_o,
    output logic                       dec_illegal_o,
    output logic                       dec_valid_o,
    input  logic                       dec_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem_pc_q   [DEPTH];
    logic [31:0]      mem_code_q [DEPTH];
    logic             mem_ill_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Ready and valid come from the occupancy register only, so there is no
    // combinational path from decode back to fetch or from fetch to decode.
    assign fetch_ready_o = (count_q != CNT_W'(DEPTH));
    assign dec_valid_o   = (count_q != '0);
    assign count_o       = count_q;

    // Head fields are masked while empty so the decoder sees an all-zero word
    // even though storage is never cleared.
    assign dec_pc_o      = dec_valid_o ? mem_pc_q[rd_ptr_q]   : '0;
    assign dec_code_o    = dec_valid_o ? mem_code_q[rd_ptr_q] : '0;
    assign dec_illegal_o = dec_valid_o ? mem_ill_q[rd_ptr_q]  : 1'b0;

    always_comb begin
        push     = fetch_valid_i && fetch_ready_o && !flush_i;
        pop      = dec_valid_o && dec_ready_i && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; stale contents are hidden by count == 0.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]   <= fetch_pc_i;
            mem_code_q[wr_ptr_q] <= fetch_code_i;
            mem_ill_q[wr_ptr_q]  <= (fetch_code_i[1:0] != 2'b11);
        end
    end

endmodule

// File: doc/instruction_queue.md
# instruction_queue

Decoupling FIFO between instruction fetch and `instruction_decoder`. Each entry holds a fetched 32-bit instruction word and its PC. The head entry is presented to the decode stage with a valid/ready handshake. A single-cycle flush discards all queued entries on redirect (branch, jump, trap). Entries whose low two bits are not `2'b11` are flagged illegal, because the core implements RV64G without the C extension.

## Interface
- `DEPTH`, default 4: number of entries; power of two, minimum 2.
- `XLEN`, default 64: PC width.

- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `arst_ni`, input, 1: asynchronous active-low reset.
- `flush_i`, input, 1: discard all entries; synchronous, highest priority.
- `fetch_pc_i`, input, XLEN: PC of the incoming instruction.
- `fetch_code_i`, input, 32: incoming instruction word.
- `fetch_valid_i`, input, 1: fetch presents an entry.
- `fetch_ready_o`, output, 1: queue accepts an entry this cycle.
- `dec_pc_o`, output, XLEN: PC of the head entry.
- `dec_code_o`, output, 32: instruction word of the head entry; this drives the decoder's `code_i`.
- `dec_illegal_o`, output, 1: head entry has `code[1:0] != 2'b11`.
- `dec_valid_o`, output, 1: head entry is valid.
- `dec_ready_i`, input, 1: decode consumes the head this cycle.
- `count_o`, output, $clog2(DEPTH)+1: number of occupied entries, 0..DEPTH.

## Operation
- **Storage:** DEPTH entries, each {pc, code, illegal}. Write pointer and read pointer are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. Occupancy is tracked by `count`.
- **Push:** occurs when `fetch_valid_i && fetch_ready_o && !flush_i`. The entry is written at the write pointer, and the write pointer increments.
- **Pop:** occurs when `dec_valid_o && dec_ready_i && !flush_i`. The read pointer increments.
- **Count update:** `count` changes by +1 (push only), −1 (pop only), or 0 (both or neither).
- **`fetch_ready_o`:** equals `count != DEPTH`. It does not depend on `dec_ready_i`: no push-through when full, so there is no combinational ready path from decode to fetch.
- **`dec_valid_o`:** equals `count != 0`. There is no bypass from fetch; an empty queue never forwards `fetch_*` combinationally.
- **Head outputs:** `dec_pc_o`, `dec_code_o` and `dec_illegal_o` are read from the entry at the read pointer. When `count == 0` they are forced to 0, so the decoder sees an all-zero word, which decodes as INVALID/zero.
- **Illegal flag:** `illegal` is computed at push time as `fetch_code_i[1:0] != 2'b11`. An illegal entry is still queued and popped normally; the flag only marks it for downstream trap handling.
- **Flush:** on a cycle with `flush_i=1`, both pointers and `count` become 0 at the next edge. Any push or pop in that cycle is ignored.
- **Handshake rules:**
  - While `dec_valid_o=1 && dec_ready_i=0`, the head outputs are held stable.
  - The queue does not require fetch to hold `fetch_*` stable while ready is low; fetch is responsible for retrying.

## Timing
- **Reset:** while `arst_ni=0`, and immediately on assertion, the following hold:
  - pointers = 0 and `count_o = 0`;
  - `fetch_ready_o = 1`;
  - `dec_valid_o = 0`;
  - `dec_pc_o = 0`, `dec_code_o = 0`, `dec_illegal_o = 0`.
- **Reset mid-operation:** all entries are lost. Storage contents need not be cleared, because they are masked by `count = 0`.
- **Latency:** an entry pushed at edge N appears on `dec_*` with `dec_valid_o=1` in the cycle after edge N (1-cycle latency). Throughput is 1 entry per cycle in steady state.
- **Full:** with `count = DEPTH`, `fetch_ready_o=0`. A pop at edge N raises `fetch_ready_o` in the cycle after N.
- **Empty with simultaneous push and pop:** a pop cannot occur when empty, since `dec_valid_o=0`. The push takes effect and `count` becomes 1.
- **Wrap-around:** pointers wrap from DEPTH-1 to 0 with no bubble.
- **Flush recovery:** after a flush at edge N, `dec_valid_o=0` in the cycle after N, and a new push is accepted in that same cycle.
- **Outputs:** all outputs are combinational from registers only. There is no input-to-output combinational path.

## Test plan
- **Reset:** assert `arst_ni=0` mid-stream with 3 entries queued → `count_o=0`, `dec_valid_o=0`, `dec_code_o=0`, `fetch_ready_o=1` immediately. Release reset and push one entry → it appears on `dec_*` the next cycle.
- **Fill/drain (DEPTH=4):** push 4 entries, PC 0x1000/0x1004/0x1008/0x100C with code 0x00000013 (`addi x0,x0,0`), while `dec_ready_i=0` → `fetch_ready_o=0` and `count_o=4`. Then drain → PCs emerge in order, and `count_o` goes 4→0.
- **Stream with wrap:** continuous push with `dec_ready_i=1` for 10 entries → one pop per cycle after the first, `count_o` stays at 1, pointers wrap twice, and no entry is lost or duplicated.
- **Backpressure hold:** with the head set to code 0x00A50533 (`add`), hold `dec_ready_i=0` for 5 cycles while fetch keeps pushing → the head is stable for 5 cycles and `count_o` saturates at 4.
- **Flush:** with 3 entries queued, assert `flush_i` together with `fetch_valid_i` and `dec_ready_i` → next cycle `count_o=0` and `dec_valid_o=0`, and neither the pushed entry nor a popped entry is observed.
- **Illegal flag:** push code 0x00004501 (compressed) → `dec_illegal_o=1` at the head. Push 0x00000013 → `dec_illegal_o=0`.
